hkspi_responder: RTL and testbench

- Housekeeping SPI slave (mode 0, MSB first) sitting on mprj_io[4:1] (SCK/CSB/SDI/SDO) in front of the housekeeping register file.
- Decodes the command byte, address byte and data bytes sent by an external host.
- Issues single-cycle register read/write strobes in the system clock domain, and raises management/user flash pass-thru requests.
- All SPI pins are oversampled by the system clock; no SCK-clocked flops.

---
 rtl/hkspi_responder.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_hkspi_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hkspi_responder.sv
// hkspi_responder
//   Housekeeping SPI slave (mode 0, MSB first). SCK, CSB and SDI are
//   oversampled by the system clock, so there are no SCK-clocked flops.
//   The responder decodes a command byte, an address byte and data bytes.
//   It issues single-cycle register read/write strobes and raises the
//   management/user flash pass-thru requests.
//
// Ports
//   clock          system clock (at least 6x SCK)
//   reset          asynchronous, active-high reset
//   SCK/CSB/SDI    SPI pins from the host (asynchronous)
//   SDO            SPI data to the host
//   sdo_enable     SDO pad output enable
//   addr           register address
//   wdata          register write data
//   wstrobe        one-cycle write pulse
//   rdata          register read data (combinational from addr)
//   rstrobe        one-cycle pulse when rdata is captured
//   pass_thru_user user-flash pass-thru active
//   pass_thru_mgmt management-flash pass-thru active
module hkspi_responder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  USER_PT_CMD = 8'hC2,
   parameter logic [7:0]  MGMT_PT_CMD = 8'hC4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       SCK,
   input  logic       CSB,
   input  logic       SDI,
   output logic       SDO,
   output logic       sdo_enable,
   output logic [7:0] addr,
   output logic [7:0] wdata,
   output logic       wstrobe,
   input  logic [7:0] rdata,
   output logic       rstrobe,
   output logic       pass_thru_user,
   output logic       pass_thru_mgmt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COMMAND,
      S_ADDRESS,
      S_DATA,
      S_PASSTHRU,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // ------------------------------------------------------------------
   // Pin synchronizers and edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_csb_sync;
   logic [SYNC_STAGES-1:0] r_sdi_sync;
   logic                   r_sck_d;
   logic                   r_csb_d;

   // The CSB chain resets low. A CSB held low through reset therefore
   // never shows up as a fall, and the host must start a fresh transaction.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sck_sync <= '0;
         r_csb_sync <= '0;
         r_sdi_sync <= '0;
         r_sck_d    <= 1'b0;
         r_csb_d    <= 1'b0;
      end else begin
         r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
         r_csb_sync <= {r_csb_sync[SYNC_STAGES-2:0], CSB};
         r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], SDI};
         r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
         r_csb_d    <= r_csb_sync[SYNC_STAGES-1];
      end
   end

   logic w_sck;
   logic w_csb;
   logic w_sdi;
   logic w_sck_rise;
   logic w_sck_fall;
   logic w_csb_fall;

   assign w_sck      = r_sck_sync[SYNC_STAGES-1];
   assign w_csb      = r_csb_sync[SYNC_STAGES-1];
   assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
   assign w_sck_rise = w_sck & ~r_sck_d;
   assign w_sck_fall = ~w_sck & r_sck_d;
   assign w_csb_fall = ~w_csb & r_csb_d;

   // ------------------------------------------------------------------
   // Bit/byte framing
   // ------------------------------------------------------------------
   logic [2:0] r_bit_cnt;
   logic [6:0] r_shift;
   logic       r_rd;
   logic       r_wr;
   logic [2:0] r_count;
   logic [2:0] r_byte_cnt;
   logic [7:0] r_addr;
   logic [7:0] r_wdata;
   logic       r_wstrobe;
   logic       r_rstrobe;
   logic [7:0] r_tx;
   logic [1:0] r_rd_cnt;
   logic       r_inc_pend;
   logic       r_pt_user;
   logic       r_pt_mgmt;

   logic       w_in_xfer;
   logic       w_rise;
   logic       w_byte_done;
   logic [7:0] w_byte;
   logic       w_last_byte;
   logic       w_sdo;
   logic       w_sdo_en;

   // A synchronized CSB high masks the SCK rise in the same cycle, so an
   // 8th rise that coincides with CSB rising is discarded.
   assign w_in_xfer   = ~w_csb & ((r_state == S_COMMAND) ||
                                  (r_state == S_ADDRESS) ||
                                  (r_state == S_DATA));
   assign w_rise      = w_sck_rise & w_in_xfer;
   assign w_byte_done = w_rise & (r_bit_cnt == 3'd7);
   assign w_byte      = {r_shift, w_sdi};
   assign w_last_byte = (r_count != 3'd0) && (r_byte_cnt == (r_count - 3'd1));

   // ------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_sdo_en     = 1'b0;
      w_sdo        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_csb_fall) begin
               w_state_next = S_COMMAND;
            end
         end
         S_COMMAND: begin
            if (w_byte_done) begin
               if ((w_byte == USER_PT_CMD) || (w_byte == MGMT_PT_CMD)) begin
                  w_state_next = S_PASSTHRU;
               end else if (w_byte[7:6] == 2'b00) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_ADDRESS;
               end
            end
         end
         S_ADDRESS: begin
            if (w_byte_done) begin
               w_state_next = S_DATA;
            end
         end
         S_DATA: begin
            w_sdo_en = r_rd;
            w_sdo    = r_rd & r_tx[7];
            if (w_byte_done && w_last_byte) begin
               w_state_next = S_DONE;
            end
         end
         default: begin
            w_state_next = r_state;
         end
      endcase
      if (w_csb) begin
         w_state_next = S_IDLE;
      end
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_rd       <= 1'b0;
         r_wr       <= 1'b0;
         r_count    <= '0;
         r_byte_cnt <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wstrobe  <= 1'b0;
         r_rstrobe  <= 1'b0;
         r_tx       <= '0;
         r_rd_cnt   <= '0;
         r_inc_pend <= 1'b0;
      end else begin
         r_wstrobe <= 1'b0;
         r_rstrobe <= 1'b0;
         if (w_csb || (r_state == S_IDLE)) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_rd_cnt   <= '0;
            r_inc_pend <= 1'b0;
         end else begin
            if (w_rise) begin
               r_shift   <= w_byte[6:0];
               r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            // The fall right after a byte boundary keeps bit 7 in place.
            // The reload of r_tx then supplies the next byte.
            if (w_sck_fall && (r_state == S_DATA) && (r_bit_cnt != 3'd0)) begin
               r_tx <= {r_tx[6:0], 1'b0};
            end

            // Capture rdata two clocks after addr changes.
            if (r_rd_cnt != 2'd0) begin
               r_rd_cnt <= r_rd_cnt - 2'd1;
               if ((r_rd_cnt == 2'd1) && (r_state == S_DATA)) begin
                  r_tx      <= rdata;
                  r_rstrobe <= 1'b1;
               end
            end

            // The address increment lags the write strobe by one clock.
            // The write therefore sees the pre-increment addr. No increment
            // happens once the byte count has moved the machine to DONE.
            if (r_inc_pend) begin
               r_inc_pend <= 1'b0;
               if (r_state == S_DATA) begin
                  r_addr <= r_addr + 8'd1;
                  if (r_rd) begin
                     r_rd_cnt <= 2'd2;
                  end
               end
            end

            if (w_byte_done) begin
               case (r_state)
                  S_COMMAND: begin
                     r_rd       <= w_byte[6];
                     r_wr       <= w_byte[7];
                     r_count    <= w_byte[5:3];
                     r_byte_cnt <= '0;
                  end
                  S_ADDRESS: begin
                     r_addr <= w_byte;
                     if (r_rd) begin
                        r_rd_cnt <= 2'd2;
                     end
                  end
                  S_DATA: begin
                     if (r_wr) begin
                        r_wdata   <= w_byte;
                        r_wstrobe <= 1'b1;
                     end
                     r_byte_cnt <= r_byte_cnt + 3'd1;
                     r_inc_pend <= 1'b1;
                  end
                  default: begin
                     r_byte_cnt <= r_byte_cnt;
                  end
               endcase
            end
         end
      end
   end

   // Pass-thru requests: set from the decoded command and held until CSB rises.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pt_user <= 1'b0;
         r_pt_mgmt <= 1'b0;
      end else if (w_csb) begin
         r_pt_user <= 1'b0;
         r_pt_mgmt <= 1'b0;
      end else if (w_byte_done && (r_state == S_COMMAND)) begin
         r_pt_user <= (w_byte == USER_PT_CMD);
         r_pt_mgmt <= (w_byte == MGMT_PT_CMD);
      end
   end

   assign SDO            = w_sdo;
   assign sdo_enable     = w_sdo_en;
   assign addr           = r_addr;
   assign wdata          = r_wdata;
   assign wstrobe        = r_wstrobe;
   assign rstrobe        = r_rstrobe;
   assign pass_thru_user = r_pt_user;
   assign pass_thru_mgmt = r_pt_mgmt;

endmodule

// File: tb/tb_hkspi_responder.sv
// tb_hkspi_responder
//   Self-checking bench for hkspi_responder. It drives host SPI transactions
//   as a mode-0 master, with SCK at 1/12 of the system clock. It logs the
//   register strobes and compares them against table entries and against
//   a transaction-level model.
module tb_hkspi_responder;

   localparam int H = 6;

   logic       clock = 1'b0;
   logic       reset;
   logic       SCK;
   logic       CSB;
   logic       SDI;
   logic       SDO;
   logic       sdo_enable;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       wstrobe;
   logic [7:0] rdata;
   logic       rstrobe;
   logic       pass_thru_user;
   logic       pass_thru_mgmt;

   // Register file stand-in: combinational from addr (0x03 -> 0x11).
   assign rdata = addr ^ 8'h12;

   always #5 clock = ~clock;

   hkspi_responder #(
      .SYNC_STAGES(2),
      .USER_PT_CMD(8'hC2),
      .MGMT_PT_CMD(8'hC4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .SCK            (SCK),
      .CSB            (CSB),
      .SDI            (SDI),
      .SDO            (SDO),
      .sdo_enable     (sdo_enable),
      .addr           (addr),
      .wdata          (wdata),
      .wstrobe        (wstrobe),
      .rdata          (rdata),
      .rstrobe        (rstrobe),
      .pass_thru_user (pass_thru_user),
      .pass_thru_mgmt (pass_thru_mgmt)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Strobe / level monitor
   logic [15:0] wq[$];
   logic [7:0]  rq[$];
   int          ptu_cyc = 0;
   int          ptm_cyc = 0;
   int          sdoen_cyc = 0;

   always @(posedge clock) begin
      if (wstrobe) wq.push_back({addr, wdata});
      if (rstrobe) rq.push_back(addr);
      if (pass_thru_user) ptu_cyc <= ptu_cyc + 1;
      if (pass_thru_mgmt) ptm_cyc <= ptm_cyc + 1;
      if (sdo_enable) sdoen_cyc <= sdoen_cyc + 1;
   end

   // Host side
   logic [7:0] rxq[$];

   task automatic clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_bit(input logic b, input bit tight, output logic r);
      SDI = b;
      clk(H);
      r = SDO;
      SCK = 1'b1;
      if (tight) begin
         clk(1);
         CSB = 1'b1;
      end
      clk(H);
      SCK = 1'b0;
   endtask

   task automatic send(input logic [7:0] v, input int nbits, input bit tight);
      logic [7:0] rx;
      logic       r;
      rx = '0;
      for (int i = 0; i < nbits; i++) begin
         send_bit(v[7-i], tight && (i == nbits - 1), r);
         rx[7-i] = r;
      end
      rxq.push_back(rx);
   endtask

   typedef struct {
      int          nb;     // bytes sent (last one may be partial)
      logic [47:0] b;      // bytes, first byte in [47:40]
      int          part;   // bits of the last byte, 0 = full byte
      bit          tight;  // CSB rises one clock after the final SCK rise
      int          nw;     // expected wstrobe count
      logic [15:0] w0;     // first {addr,wdata}
      logic [15:0] wl;     // last {addr,wdata}
      int          nr;     // expected rstrobe count
      logic [7:0]  ra0;    // addr at first rstrobe
      logic [7:0]  ea;     // addr after the transaction
      logic [7:0]  rx;     // host-received first data byte
      bit          ptu;
      bit          ptm;
      bit          sdoen;
   } vec_t;

   task automatic drive(input vec_t v);
      logic [47:0] bb;
      int          nbits;
      bit          t;
      bb = v.b;
      t  = 1'b0;
      rxq.delete();
      CSB = 1'b0;
      clk(H);
      for (int j = 0; j < v.nb; j++) begin
         nbits = ((j == v.nb - 1) && (v.part != 0)) ? v.part : 8;
         t = v.tight && (j == v.nb - 1) && (nbits == 8);
         send(bb[47-8*j -: 8], nbits, t);
      end
      if (!t) begin
         clk(H);
         CSB = 1'b1;
      end
      clk(12);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int wb, rb, pu, pm, se;
      wb = wq.size();
      rb = rq.size();
      pu = ptu_cyc;
      pm = ptm_cyc;
      se = sdoen_cyc;
      drive(v);
      check({tag, " wcount"}, 32'(wq.size() - wb), 32'(v.nw));
      if (v.nw > 0 && wq.size() > wb) begin
         check({tag, " wfirst"}, 32'(wq[wb]), 32'(v.w0));
         check({tag, " wlast"}, 32'(wq[wq.size()-1]), 32'(v.wl));
      end
      check({tag, " rcount"}, 32'(rq.size() - rb), 32'(v.nr));
      if (v.nr > 0 && rq.size() > rb) begin
         check({tag, " raddr"}, 32'(rq[rb]), 32'(v.ra0));
         check({tag, " rxbyte"}, 32'(rxq[2]), 32'(v.rx));
      end
      check({tag, " addr"}, 32'(addr), 32'(v.ea));
      check({tag, " pt_user"}, 32'(ptu_cyc != pu), 32'(v.ptu));
      check({tag, " pt_mgmt"}, 32'(ptm_cyc != pm), 32'(v.ptm));
      check({tag, " sdo_en"}, 32'(sdoen_cyc != se), 32'(v.sdoen));
   endtask

   vec_t vt[10];

   initial begin
      logic       r;
      int         cnt;
      int         wb;
      vec_t       rv;
      logic [7:0] m_addr;
      logic [7:0] cmd, a, cur;
      logic [7:0] dq[4];
      int         nd;
      bit         late;
      logic [15:0] ew[$];
      logic [7:0]  er[$];
      logic [7:0]  erx[$];
      bit         e_pu, e_pm, done;
      int         rb, pu, pm;

      //        nb  bytes                                  part tight nw  w0        wl        nr ra0    ea     rx     ptu ptm sdoen
      vt[0] = '{3, {8'h40, 8'h03, 8'h00, 24'h0},            0, 1,   0, 16'h0,    16'h0,    1, 8'h03, 8'h03, 8'h11, 0, 0, 1};
      vt[1] = '{3, {8'h80, 8'h0B, 8'h01, 24'h0},            0, 1,   1, 16'h0B01, 16'h0B01, 0, 8'h00, 8'h0B, 8'h00, 0, 0, 0};
      vt[2] = '{3, {8'h80, 8'h0B, 8'h00, 24'h0},            0, 1,   1, 16'h0B00, 16'h0B00, 0, 8'h00, 8'h0B, 8'h00, 0, 0, 0};
      vt[3] = '{4, {8'h80, 8'hFF, 8'hAA, 8'h55, 16'h0},     0, 0,   2, 16'hFFAA, 16'h0055, 0, 8'h00, 8'h01, 8'h00, 0, 0, 0};
      vt[4] = '{4, {8'h88, 8'h10, 8'h5A, 8'hA5, 16'h0},     0, 0,   1, 16'h105A, 16'h105A, 0, 8'h00, 8'h10, 8'h00, 0, 0, 0};
      vt[5] = '{6, {8'hC2, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 0, 0, 0, 16'h0,    16'h0,    0, 8'h00, 8'h10, 8'h00, 1, 0, 0};
      vt[6] = '{6, {8'hC4, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 0, 0, 0, 16'h0,    16'h0,    0, 8'h00, 8'h10, 8'h00, 0, 1, 0};
      vt[7] = '{3, {8'h80, 8'h20, 8'hF0, 24'h0},            4, 0,   0, 16'h0,    16'h0,    0, 8'h00, 8'h20, 8'h00, 0, 0, 0};
      vt[8] = '{3, {8'hC0, 8'hFF, 8'h77, 24'h0},            0, 0,   1, 16'hFF77, 16'hFF77, 2, 8'hFF, 8'h00, 8'hED, 0, 0, 1};
      vt[9] = '{4, {8'h48, 8'h05, 8'h00, 8'h00, 16'h0},     0, 0,   0, 16'h0,    16'h0,    1, 8'h05, 8'h05, 8'h17, 0, 0, 1};

      reset = 1'b1;
      SCK   = 1'b0;
      CSB   = 1'b1;
      SDI   = 1'b0;
      clk(3);
      check("rst SDO", 32'(SDO), 0);
      check("rst sdo_enable", 32'(sdo_enable), 0);
      check("rst addr", 32'(addr), 0);
      check("rst wdata", 32'(wdata), 0);
      check("rst strobes", 32'({wstrobe, rstrobe}), 0);
      check("rst pass_thru", 32'({pass_thru_user, pass_thru_mgmt}), 0);
      reset = 1'b0;
      clk(5);

      for (int i = 0; i < 10; i++) begin
         run_vec(vt[i], $sformatf("vec%0d", i));
      end

      // Pass-thru timing: request follows the 8th rise; it drops within 3 clocks of CSB high.
      CSB = 1'b0;
      clk(H);
      send(8'hC4, 7, 0);
      check("pt before 8th rise", 32'(pass_thru_mgmt), 0);
      send_bit(1'b0, 0, r);
      check("pt after 8th rise", 32'(pass_thru_mgmt), 1);
      check("pt user idle", 32'(pass_thru_user), 0);
      send(8'h5A, 8, 0);
      send(8'h3C, 8, 0);
      check("pt held", 32'(pass_thru_mgmt), 1);
      CSB = 1'b1;
      cnt = 0;
      while (pass_thru_mgmt && cnt < 10) begin
         clk(1);
         cnt++;
      end
      check("pt deassert clocks<=3", 32'(cnt <= 3), 1);
      clk(12);

      // CSB rises in the same cycle as the 8th data rise: the byte is dropped.
      wb = wq.size();
      CSB = 1'b0;
      clk(H);
      send(8'h80, 8, 0);
      send(8'h31, 8, 0);
      send(8'h99, 7, 0);
      SDI = 1'b1;
      clk(H);
      SCK = 1'b1;
      CSB = 1'b1;
      clk(H);
      SCK = 1'b0;
      clk(12);
      check("simul csb wcount", 32'(wq.size() - wb), 0);
      check("simul csb addr", 32'(addr), 32'h31);

      // Reset in the middle of a read.
      CSB = 1'b0;
      clk(H);
      send(8'h40, 8, 0);
      send(8'h03, 8, 0);
      send(8'h00, 3, 0);
      clk(4);
      check("pre-reset sdo_enable", 32'(sdo_enable), 1);
      check("pre-reset SDO bit4", 32'(SDO), 1);
      reset = 1'b1;
      #1;
      check("reset SDO", 32'(SDO), 0);
      check("reset sdo_enable", 32'(sdo_enable), 0);
      check("reset rstrobe", 32'(rstrobe), 0);
      check("reset addr", 32'(addr), 0);
      clk(2);
      reset = 1'b0;
      clk(4);
      CSB = 1'b1;
      SCK = 1'b0;
      clk(12);
      run_vec(vt[0], "post-reset read");

      // Randomized transactions against a transaction-level model.
      m_addr = 8'h03;
      for (int it = 0; it < 30; it++) begin
         cmd = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
         if ($urandom_range(0, 3) == 0) cmd[5:3] = 3'd0;
         if (it == 7) cmd = 8'hC2;
         a    = 8'($urandom);
         nd   = $urandom_range(1, 4);
         late = 1'($urandom_range(0, 1));
         for (int k = 0; k < 4; k++) dq[k] = 8'($urandom);

         ew.delete();
         er.delete();
         erx.delete();
         e_pu = (cmd == 8'hC2);
         e_pm = (cmd == 8'hC4);
         for (int k = 0; k < nd; k++) erx.push_back(8'h00);
         if (!e_pu && !e_pm && cmd[7:6] != 2'b00) begin
            cur  = a;
            done = 1'b0;
            if (cmd[6]) er.push_back(cur);
            for (int k = 0; k < nd; k++) begin
               if (!done) begin
                  if (cmd[6]) erx[k] = cur ^ 8'h12;
                  if (cmd[7]) ew.push_back({cur, dq[k]});
                  if (cmd[5:3] != 3'd0 && (k + 1) == int'(cmd[5:3])) begin
                     done = 1'b1;
                  end else if (k < nd - 1 || late) begin
                     cur = cur + 8'd1;
                     if (cmd[6]) er.push_back(cur);
                  end
               end
            end
            m_addr = cur;
         end

         rv       = vt[0];
         rv.nb    = nd + 2;
         rv.b     = {cmd, a, dq[0], dq[1], dq[2], dq[3]};
         rv.part  = 0;
         rv.tight = !late;
         wb = wq.size();
         rb = rq.size();
         pu = ptu_cyc;
         pm = ptm_cyc;
         drive(rv);

         check($sformatf("rnd%0d wcount", it), 32'(wq.size() - wb), 32'(ew.size()));
         for (int k = 0; k < ew.size(); k++) begin
            if (wb + k < wq.size())
               check($sformatf("rnd%0d w%0d", it, k), 32'(wq[wb+k]), 32'(ew[k]));
         end
         check($sformatf("rnd%0d rcount", it), 32'(rq.size() - rb), 32'(er.size()));
         for (int k = 0; k < er.size(); k++) begin
            if (rb + k < rq.size())
               check($sformatf("rnd%0d r%0d", it, k), 32'(rq[rb+k]), 32'(er[k]));
         end
         for (int k = 0; k < nd; k++) begin
            check($sformatf("rnd%0d rx%0d", it, k), 32'(rxq[k+2]), 32'(erx[k]));
         end
         check($sformatf("rnd%0d addr", it), 32'(addr), 32'(m_addr));
         check($sformatf("rnd%0d pt_user", it), 32'(ptu_cyc != pu), 32'(e_pu));
         check($sformatf("rnd%0d pt_mgmt", it), 32'(ptm_cyc != pm), 32'(e_pm));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
